// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: types and constants shared by the branch controller,
// its counter table and jump_control.
//   - BJ_OP_BUS / bj_op_t / EXE_BJOP_*  : branch/jump opcode encodings
//   - BHT_SNT..BHT_ST                    : 2-bit bimodal counter states
//   - bc_state_t                         : redirect sequencer states
//   - helpers classifying opcodes and saturating a counter
package branch_ctrl_pkg;

  localparam int BJ_OP_BUS = 4;
  typedef logic [BJ_OP_BUS-1:0] bj_op_t;

  localparam bj_op_t EXE_BJOP_NOOP = 4'd0;
  localparam bj_op_t EXE_BJOP_BEQ  = 4'd1;
  localparam bj_op_t EXE_BJOP_BNE  = 4'd2;
  localparam bj_op_t EXE_BJOP_BLT  = 4'd3;
  localparam bj_op_t EXE_BJOP_BGE  = 4'd4;
  localparam bj_op_t EXE_BJOP_BLTU = 4'd5;
  localparam bj_op_t EXE_BJOP_BGEU = 4'd6;
  localparam bj_op_t EXE_BJOP_JUMP = 4'd7;

  localparam logic [1:0] BHT_SNT = 2'd0;
  localparam logic [1:0] BHT_WNT = 2'd1;
  localparam logic [1:0] BHT_WT  = 2'd2;
  localparam logic [1:0] BHT_ST  = 2'd3;

  typedef enum logic [0:0] {
    BC_IDLE     = 1'b0,
    BC_REDIRECT = 1'b1
  } bc_state_t;

  // Conditional branches are the only ops that train the table.
  function automatic logic is_cond_op(input bj_op_t op);
    case (op)
      EXE_BJOP_BEQ, EXE_BJOP_BNE, EXE_BJOP_BLT,
      EXE_BJOP_BGE, EXE_BJOP_BLTU, EXE_BJOP_BGEU: is_cond_op = 1'b1;
      default:                                    is_cond_op = 1'b0;
    endcase
  endfunction

  // Undefined encodings fall out as "not a branch/jump".
  function automatic logic is_bj_op(input bj_op_t op);
    is_bj_op = is_cond_op(op) | (op == EXE_BJOP_JUMP);
  endfunction

  function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      bht_sat_update = (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
    end else begin
      bht_sat_update = (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/branch_ctrl_bht_2bit.sv
// bht_2bit: array of 2-bit saturating counters.
//   clk, rst         : clock, synchronous active-high reset (all -> weakly not-taken)
//   rd_idx / rd_ctr  : combinational read port (returns pre-update value)
//   wr_en, wr_idx,
//   wr_taken         : registered saturating update, visible next cycle
module bht_2bit
  import branch_ctrl_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_r [ENTRIES];

  assign rd_ctr = ctr_r[rd_idx];

  // Counter storage: whole-table reset in one cycle, single saturating write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= BHT_WNT;
      end
    end else if (wr_en) begin
      ctr_r[wr_idx] <= bht_sat_update(ctr_r[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: bimodal branch predictor plus mispredict redirect sequencer.
//   clk, rst                         : clock, synchronous active-high reset
//   if_pc, if_is_cbranch, if_is_jump : fetch-side lookup; if_pred_taken (comb)
//   ex_*                             : instruction resolving in EX
//   redirect_valid/ready/pc          : PC override handshake to fetch
//   flush_ifid                       : kill IF/ID and ID/EX while redirecting
//   branch_cnt, mispred_cnt          : performance counters (wrap mod 2^32)
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_cbranch,
  input  logic            if_is_jump,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  bj_op_t          ex_bj_op,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_b_taken,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       if_ctr;
  logic             resolve;
  logic             mispredict;
  logic             train_en;
  logic [XLEN-1:0]  corrected_pc;
  bc_state_t        state_r;
  bc_state_t        state_nxt;
  logic [XLEN-1:0]  redirect_pc_r;
  logic [31:0]      branch_cnt_r;
  logic [31:0]      mispred_cnt_r;
  logic             unused_bits;

  // Word-aligned PCs: bits [1:0] never vary, so indexing starts at bit 2.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], if_ctr[0]};

  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_idx),
    .rd_ctr   (if_ctr),
    .wr_en    (train_en),
    .wr_idx   (ex_idx),
    .wr_taken (ex_b_taken)
  );

  assign if_pred_taken = if_is_jump | (if_is_cbranch & if_ctr[1]);

  // Resolve/mispredict decode; wrong-path EX contents are ignored outside IDLE.
  always_comb begin
    resolve = 1'b0;
    if (ex_valid && !ex_stall && (state_r == BC_IDLE) && is_bj_op(ex_bj_op)) begin
      resolve = 1'b1;
    end else begin
      resolve = 1'b0;
    end
    mispredict   = resolve & ((ex_b_taken != ex_pred_taken) |
                              (ex_b_taken & ex_pred_taken & (ex_target != ex_pred_target)));
    train_en     = resolve & is_cond_op(ex_bj_op);
    corrected_pc = ex_b_taken ? ex_target : (ex_pc + XLEN'(3'd4));
  end

  // State register; redirect_pc is captured on the mispredict edge and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= BC_IDLE;
      redirect_pc_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt;
      if (mispredict) begin
        redirect_pc_r <= corrected_pc;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      BC_IDLE: begin
        if (mispredict) state_nxt = BC_REDIRECT;
        else            state_nxt = BC_IDLE;
      end
      BC_REDIRECT: begin
        if (redirect_ready) state_nxt = BC_IDLE;
        else                state_nxt = BC_REDIRECT;
      end
      default: state_nxt = BC_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    redirect_valid = 1'b0;
    flush_ifid     = 1'b0;
    case (state_r)
      BC_REDIRECT: begin
        redirect_valid = 1'b1;
        flush_ifid     = 1'b1;
      end
      default: begin
        redirect_valid = 1'b0;
        flush_ifid     = 1'b0;
      end
    endcase
    redirect_pc = redirect_pc_r;
  end

  // Performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (resolve)    branch_cnt_r  <= branch_cnt_r + 32'd1;
      if (mispredict) mispred_cnt_r <= mispred_cnt_r + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_r;
  assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_is_cbranch, if_is_jump, if_pred_taken;
  logic        ex_valid, ex_stall;
  logic [31:0] ex_pc;
  bj_op_t      ex_bj_op;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target, ex_target;
  logic        ex_b_taken;
  logic        redirect_valid, redirect_ready, flush_ifid;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  branch_ctrl #(.BHT_ENTRIES(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_is_cbranch(if_is_cbranch), .if_is_jump(if_is_jump),
    .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_bj_op(ex_bj_op),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_target(ex_target), .ex_b_taken(ex_b_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bj_op_t      op;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] ptgt;
    logic [31:0] tgt;
    logic        taken;
    logic        exp_rv;
    logic [31:0] exp_rpc;
    logic        pred_before;
    logic        pred_after;
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];
  vec_t got;
  int   checks = 0;
  int   errors = 0;
  int   br_m = 0;
  int   mp_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input bj_op_t op, input logic [31:0] pc, input logic pred,
                          input logic [31:0] ptgt, input logic [31:0] tgt, input logic taken);
    ex_valid = 1'b1; ex_bj_op = op; ex_pc = pc; ex_pred_taken = pred;
    ex_pred_target = ptgt; ex_target = tgt; ex_b_taken = taken;
  endtask

  initial begin
    // op, pc, pred, ptgt, tgt, taken, exp_rv, exp_rpc, pred_before, pred_after
    tbl[0]  = '{EXE_BJOP_BNE,  32'h200, 1'b0, 32'h0,    32'h240,  1'b1, 1'b1, 32'h240, 1'b0, 1'b1};
    tbl[1]  = '{EXE_BJOP_BNE,  32'h200, 1'b1, 32'h240,  32'h240,  1'b1, 1'b0, 32'h0,   1'b1, 1'b1};
    tbl[2]  = '{EXE_BJOP_BNE,  32'h200, 1'b1, 32'h240,  32'h240,  1'b1, 1'b0, 32'h0,   1'b1, 1'b1};
    tbl[3]  = '{EXE_BJOP_BNE,  32'h200, 1'b1, 32'h240,  32'h240,  1'b0, 1'b1, 32'h204, 1'b1, 1'b1};
    tbl[4]  = '{EXE_BJOP_BNE,  32'h200, 1'b0, 32'h0,    32'h240,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[5]  = '{EXE_BJOP_BNE,  32'h200, 1'b0, 32'h0,    32'h240,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[6]  = '{EXE_BJOP_BNE,  32'h200, 1'b0, 32'h0,    32'h240,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[7]  = '{EXE_BJOP_BNE,  32'h200, 1'b0, 32'h0,    32'h240,  1'b1, 1'b1, 32'h240, 1'b0, 1'b0};
    tbl[8]  = '{EXE_BJOP_JUMP, 32'h304, 1'b1, 32'h300,  32'h380,  1'b1, 1'b1, 32'h380, 1'b0, 1'b0};
    tbl[9]  = '{EXE_BJOP_BLTU, 32'hFFFF_FFFC, 1'b1, 32'h1000, 32'h1000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{EXE_BJOP_BLT,  32'h404, 1'b1, 32'h500,  32'h500,  1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
    tbl[11] = '{4'hF,          32'h404, 1'b0, 32'h0,    32'h500,  1'b0, 1'b0, 32'h0,   1'b1, 1'b1};
    tbl[12] = '{EXE_BJOP_BGE,  32'h408, 1'b1, 32'h600,  32'h604,  1'b1, 1'b1, 32'h604, 1'b0, 1'b1};
    tbl[13] = '{EXE_BJOP_BGEU, 32'h40C, 1'b0, 32'h0,    32'h800,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[14] = '{EXE_BJOP_BEQ,  32'h410, 1'b1, 32'h700,  32'h700,  1'b0, 1'b1, 32'h414, 1'b0, 1'b0};
    tbl[15] = '{EXE_BJOP_NOOP, 32'h200, 1'b0, 32'h0,    32'h240,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0};

    rst = 1'b1; if_pc = 32'h0; if_is_cbranch = 1'b0; if_is_jump = 1'b0;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = 32'h0; ex_bj_op = EXE_BJOP_NOOP;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0; ex_target = 32'h0; ex_b_taken = 1'b0;
    redirect_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and first lookup
    if_pc = 32'h100; if_is_cbranch = 1'b1;
    #1;
    check("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    check("reset_rv", {31'd0, redirect_valid}, 32'd0);
    check("reset_flush", {31'd0, flush_ifid}, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);
    check("reset_brcnt", branch_cnt, 32'd0);
    check("reset_mpcnt", mispred_cnt, 32'd0);
    if_is_jump = 1'b1; if_is_cbranch = 1'b0;
    #1;
    check("jump_pred", {31'd0, if_pred_taken}, 32'd1);
    if_is_jump = 1'b0; if_is_cbranch = 1'b1;

    // Mispredicted BEQ, redirect held while ready is low, wrong-path resolves ignored
    drive_ex(EXE_BJOP_BEQ, 32'h100, 1'b0, 32'h0, 32'h140, 1'b1);
    tick();
    check("beq_rv", {31'd0, redirect_valid}, 32'd1);
    check("beq_rpc", redirect_pc, 32'h140);
    check("beq_flush", {31'd0, flush_ifid}, 32'd1);
    check("beq_mpcnt", mispred_cnt, 32'd1);
    check("beq_brcnt", branch_cnt, 32'd1);
    check("beq_pred", {31'd0, if_pred_taken}, 32'd1);
    drive_ex(EXE_BJOP_BEQ, 32'h100, 1'b1, 32'h140, 32'h140, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rv", {31'd0, redirect_valid}, 32'd1);
      check("hold_rpc", redirect_pc, 32'h140);
      check("hold_flush", {31'd0, flush_ifid}, 32'd1);
      check("hold_mpcnt", mispred_cnt, 32'd1);
      check("hold_brcnt", branch_cnt, 32'd1);
      check("hold_pred", {31'd0, if_pred_taken}, 32'd1);
    end
    ex_valid = 1'b0; redirect_ready = 1'b1;
    tick();
    check("release_rv", {31'd0, redirect_valid}, 32'd0);
    check("release_flush", {31'd0, flush_ifid}, 32'd0);

    // Reset restores the table and counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_pred", {31'd0, if_pred_taken}, 32'd0);
    check("rst2_brcnt", branch_cnt, 32'd0);
    check("rst2_mpcnt", mispred_cnt, 32'd0);

    // Table-driven resolves with scoreboard
    for (int i = 0; i < 16; i++) begin
      drive_ex(tbl[i].op, tbl[i].pc, tbl[i].pred, tbl[i].ptgt, tbl[i].tgt, tbl[i].taken);
      if_pc = tbl[i].pc; if_is_cbranch = 1'b1;
      exp_q.push_back(tbl[i]);
      #1;
      check($sformatf("v%0d_pred_before", i), {31'd0, if_pred_taken}, {31'd0, tbl[i].pred_before});
      tick();
      ex_valid = 1'b0;
      got = exp_q.pop_front();
      if (got.op >= EXE_BJOP_BEQ && got.op <= EXE_BJOP_JUMP) br_m++;
      if (got.exp_rv) mp_m++;
      check($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, {31'd0, got.exp_rv});
      check($sformatf("v%0d_flush", i), {31'd0, flush_ifid}, {31'd0, got.exp_rv});
      if (got.exp_rv) check($sformatf("v%0d_rpc", i), redirect_pc, got.exp_rpc);
      check($sformatf("v%0d_pred_after", i), {31'd0, if_pred_taken}, {31'd0, got.pred_after});
      check($sformatf("v%0d_brcnt", i), branch_cnt, br_m);
      check($sformatf("v%0d_mpcnt", i), mispred_cnt, mp_m);
      if (got.exp_rv) begin
        tick();
        check($sformatf("v%0d_rv_drop", i), {31'd0, redirect_valid}, 32'd0);
      end
    end

    // Stall: the branch resolves once, on the first unstalled cycle
    if_pc = 32'h500;
    drive_ex(EXE_BJOP_BEQ, 32'h500, 1'b1, 32'h540, 32'h540, 1'b1);
    ex_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_brcnt", branch_cnt, br_m);
      check("stall_pred", {31'd0, if_pred_taken}, 32'd0);
    end
    ex_stall = 1'b0;
    tick();
    ex_valid = 1'b0;
    br_m++;
    check("unstall_brcnt", branch_cnt, br_m);
    check("unstall_pred", {31'd0, if_pred_taken}, 32'd1);
    check("unstall_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    check("after_stall_brcnt", branch_cnt, br_m);

    // Reset in the middle of a redirect
    redirect_ready = 1'b0;
    drive_ex(EXE_BJOP_BEQ, 32'h600, 1'b0, 32'h0, 32'h640, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("mid_rv", {31'd0, redirect_valid}, 32'd1);
    check("mid_rpc", redirect_pc, 32'h640);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rv", {31'd0, redirect_valid}, 32'd0);
    check("midrst_flush", {31'd0, flush_ifid}, 32'd0);
    check("midrst_rpc", redirect_pc, 32'd0);
    check("midrst_brcnt", branch_cnt, 32'd0);
    check("midrst_mpcnt", mispred_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
